// File: rtl/micro_hash_miner.sv
// Toy proof-of-work miner: expands a 16-byte message to 32 bytes, runs 32 byte-wide
// mixing rounds per nonce, and searches up to MAX_TRIES consecutive nonces for a hash below target.
module micro_hash_miner #(
  parameter int MAX_TRIES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        selector,
  input  logic [95:0] data_entry_12,
  input  logic [31:0] data_nonce,
  input  logic [7:0]  data_target,
  output logic [23:0] data_out_cond,
  output logic [31:0] nonce_out,
  output logic        busy,
  output logic        done,
  output logic        found
);

  typedef enum logic [2:0] {IDLE, EXPAND, ROUND, CHECK, DONE} state_t;

  // 17 bits so that a search of exactly 2^16 nonces can be expressed.
  localparam logic [16:0] TRIES_LIMIT = 17'(MAX_TRIES);

  state_t      state_q;
  logic [95:0] hdr_q;
  logic [31:0] nonce_q;
  logic [7:0]  target_q;
  logic [7:0]  exp_q [16];
  logic [7:0]  a_q, b_q, c_q;
  logic [4:0]  idx_q;
  logic [16:0] tries_q;
  logic [23:0] hash_q;
  logic [31:0] nonce_out_q;
  logic        busy_q, done_q, found_q;

  logic [7:0]  w [32];
  logic [4:0]  exp_i;
  logic [7:0]  exp_d;
  logic        late;
  logic [7:0]  x, k, c_d;
  logic [7:0]  h0, h1, h2;
  logic        pass, last_try, active;

  // Message schedule view: header bytes, then nonce bytes (MSB first), then expanded words.
  always_comb begin
    for (int j = 0; j < 12; j++) w[j] = hdr_q[95-8*j -: 8];
    for (int j = 0; j < 4; j++)  w[12+j] = nonce_q[31-8*j -: 8];
    for (int j = 0; j < 16; j++) w[16+j] = exp_q[j];
  end

  assign exp_i = {1'b1, idx_q[3:0]};
  assign exp_d = w[exp_i - 5'd3] | (w[exp_i - 5'd9] ^ w[exp_i - 5'd14]);

  // Rounds 0..16 mix a with b, later rounds mix a with c under a different constant.
  assign late = (idx_q > 5'd16);
  assign x    = late ? (a_q ^ c_q) : (a_q ^ b_q);
  assign k    = late ? 8'hA1 : 8'h99;
  assign c_d  = x + k + w[idx_q];

  assign h0 = 8'h01 + a_q;
  assign h1 = 8'h89 + b_q;
  assign h2 = 8'hFE + c_q;

  // A zero target can never pass since no unsigned byte is below zero.
  assign pass     = (h0 < target_q) && (h1 < target_q);
  assign last_try = ((tries_q + 17'd1) == TRIES_LIMIT);
  assign active   = (state_q == EXPAND) || (state_q == ROUND) || (state_q == CHECK);

  // NOTE: every register here updates with <= so all a/b/c/W updates in a round see
  // the pre-edge values, which is exactly the simultaneous update the algorithm needs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      hdr_q       <= '0;
      nonce_q     <= '0;
      target_q    <= '0;
      for (int j = 0; j < 16; j++) exp_q[j] <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      idx_q       <= '0;
      tries_q     <= '0;
      hash_q      <= '0;
      nonce_out_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      found_q     <= 1'b0;
    end else if (active && !selector) begin
      // Abort wins over everything else in flight, including a passing CHECK.
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      found_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (selector) begin
            hdr_q    <= data_entry_12;
            nonce_q  <= data_nonce;
            target_q <= data_target;
            tries_q  <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= EXPAND;
          end
        end
        EXPAND: begin
          exp_q[idx_q[3:0]] <= exp_d;
          if (idx_q == 5'd15) begin
            idx_q   <= '0;
            a_q     <= 8'h01;
            b_q     <= 8'h89;
            c_q     <= 8'hFE;
            state_q <= ROUND;
          end else begin
            idx_q <= idx_q + 5'd1;
          end
        end
        ROUND: begin
          a_q <= b_q ^ c_q;
          b_q <= {c_q[3:0], 4'h0};
          c_q <= c_d;
          if (idx_q == 5'd31) begin
            idx_q   <= '0;
            state_q <= CHECK;
          end else begin
            idx_q <= idx_q + 5'd1;
          end
        end
        CHECK: begin
          hash_q      <= {h0, h1, h2};
          nonce_out_q <= nonce_q;
          if (pass || last_try) begin
            found_q <= pass;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else begin
            nonce_q <= nonce_q + 32'd1;
            tries_q <= tries_q + 17'd1;
            idx_q   <= '0;
            state_q <= EXPAND;
          end
        end
        DONE: begin
          if (!selector) begin
            done_q  <= 1'b0;
            found_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out_cond = hash_q;
  assign nonce_out     = nonce_out_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign found         = found_q;

endmodule
